// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// Contents: FSM state enum, SYNC pattern, {dp,dm} line encodings,
// EOP length and the NRZI next-level helper.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Line encodings as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int EOP_SE0_BITS = 2;

    // NRZI: a 0 toggles J/K, a 1 holds the current level.
    function automatic logic [1:0] nrzi_level(input logic [1:0] level, input logic bit_val);
        if (bit_val) begin
            return level;
        end
        return (level == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/tx_flex_counter.sv
// Loadable-rollover counter used as the bit timer and the bit-in-byte counter.
// Ports:
//   clk, n_rst      clock, synchronous active-high reset
//   clear           forces the count to 0 (priority over count_enable)
//   count_enable    advance by one; at rollover_val the next value is 1
//   rollover_val    terminal count
//   count_out       current count
//   rollover_flag   registered, high exactly while count_out == rollover_val
module tx_flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] next_count;

    always_comb begin
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                next_count = NUM_CNT_BITS'(1);
            end else begin
                next_count = count_out + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= (next_count == rollover_val);
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSB-first data with bit
// stuffing and NRZI, then EOP (two SE0 bit periods and one J period).
// Ports:
//   clk, n_rst            clock, synchronous active-high reset
//   tx_data/tx_last       byte to send and end-of-packet marker
//   tx_data_valid         byte available; in IDLE it also starts a packet
//   tx_data_ready         one-cycle pulse when the byte is consumed
//   dp_out, dm_out        line drive ({dp,dm}: J=10, K=01, SE0=00)
//   tx_busy/tx_done/tx_error  status and end-of-packet pulses
//   state_dbg, bit_cnt_dbg, bit_timer_dbg  internal state for observation
// Handshake: tx_data, tx_last and tx_data_valid are only looked at on the
// bit strobe that ends a byte; tx_data_ready is high on exactly that cycle
// when the byte is taken, and upstream may change the data on the next cycle.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output tx_state_t  state_dbg,
    output logic [3:0] bit_cnt_dbg,
    output logic [$clog2(CLKS_PER_BIT+1)-1:0] bit_timer_dbg
);

    localparam int TIMER_BITS = $clog2(CLKS_PER_BIT + 1);

    tx_state_t   state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  ones_q, ones_d, ones_inc;
    logic [1:0]  line_q, line_d;
    logic [1:0]  se0_cnt_q, se0_cnt_d;
    logic        last_q, last_d;
    logic        underrun_q, underrun_d;
    logic        stuff_eop_q, stuff_eop_d;

    logic        start, bit_strobe, byte_end, go_eop, nxt_bit, need_stuff;
    logic        timer_en, bitcnt_en, cnt_clear;

    tx_flex_counter #(.NUM_CNT_BITS(TIMER_BITS)) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (timer_en),
        .rollover_val (TIMER_BITS'(CLKS_PER_BIT)),
        .count_out    (bit_timer_dbg),
        .rollover_flag(bit_strobe)
    );

    // Counts 1..8 while bit k (0-based) of the byte is on the line, so its
    // flag marks the last bit. It holds during a stuffed bit.
    tx_flex_counter #(.NUM_CNT_BITS(4)) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (bitcnt_en),
        .rollover_val (4'd8),
        .count_out    (bit_cnt_dbg),
        .rollover_flag(byte_end)
    );

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            ones_q      <= '0;
            line_q      <= LINE_J;
            se0_cnt_q   <= '0;
            last_q      <= 1'b0;
            underrun_q  <= 1'b0;
            stuff_eop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            ones_q      <= ones_d;
            line_q      <= line_d;
            se0_cnt_q   <= se0_cnt_d;
            last_q      <= last_d;
            underrun_q  <= underrun_d;
            stuff_eop_q <= stuff_eop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        ones_d        = ones_q;
        line_d        = line_q;
        se0_cnt_d     = se0_cnt_q;
        last_d        = last_q;
        underrun_d    = underrun_q;
        stuff_eop_d   = stuff_eop_q;
        tx_data_ready = 1'b0;
        tx_done       = 1'b0;
        tx_error      = 1'b0;
        go_eop        = 1'b0;
        nxt_bit       = shreg_q[1];
        start         = 1'b0;
        ones_inc      = shreg_q[0] ? (ones_q + 3'd1) : 3'd0;
        need_stuff    = (ones_inc == 3'(STUFF_LIMIT));

        case (state_q)
            ST_IDLE: begin
                line_d = LINE_J;
                if (tx_data_valid) begin
                    start       = 1'b1;
                    state_d     = ST_SYNC;
                    shreg_d     = SYNC_BYTE;
                    line_d      = nrzi_level(LINE_J, SYNC_BYTE[0]);
                    ones_d      = '0;
                    last_d      = 1'b0;
                    underrun_d  = 1'b0;
                    stuff_eop_d = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (bit_strobe) begin
                    ones_d = ones_inc;
                    if (byte_end) begin
                        if (last_q) begin
                            go_eop = 1'b1;
                        end else if (tx_data_valid) begin
                            shreg_d       = tx_data;
                            last_d        = tx_last;
                            tx_data_ready = 1'b1;
                            nxt_bit       = tx_data[0];
                        end else begin
                            tx_error   = 1'b1;
                            underrun_d = 1'b1;
                            go_eop     = 1'b1;
                        end
                    end else begin
                        shreg_d = shreg_q >> 1;
                    end
                    // shreg_d[0] is now the bit that follows, so a stuffed
                    // period never needs to touch the shift register.
                    if (need_stuff) begin
                        state_d     = ST_STUFF;
                        stuff_eop_d = go_eop;
                        line_d      = nrzi_level(line_q, 1'b0);
                    end else if (go_eop) begin
                        state_d   = ST_EOP_SE0;
                        se0_cnt_d = '0;
                        line_d    = LINE_SE0;
                    end else begin
                        state_d = byte_end ? ST_DATA : state_q;
                        line_d  = nrzi_level(line_q, nxt_bit);
                    end
                end
            end
            ST_STUFF: begin
                if (bit_strobe) begin
                    ones_d = '0;
                    if (stuff_eop_q) begin
                        state_d   = ST_EOP_SE0;
                        se0_cnt_d = '0;
                        line_d    = LINE_SE0;
                    end else begin
                        state_d = ST_DATA;
                        line_d  = nrzi_level(line_q, shreg_q[0]);
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_strobe) begin
                    if (se0_cnt_q == 2'(EOP_SE0_BITS - 1)) begin
                        state_d = ST_EOP_J;
                        line_d  = LINE_J;
                    end else begin
                        se0_cnt_d = se0_cnt_q + 2'd1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_strobe) begin
                    state_d = ST_IDLE;
                    tx_done = !underrun_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = LINE_J;
            end
        endcase
    end

    assign cnt_clear = (state_d == ST_IDLE);
    assign timer_en  = (state_q != ST_IDLE) || start;
    assign bitcnt_en = start || (bit_strobe && ((state_d == ST_SYNC) || (state_d == ST_DATA)));

    assign dp_out    = line_q[1];
    assign dm_out    = line_q[0];
    assign tx_busy   = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
module tb_usb_tx_encoder;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_last;
  logic       tx_data_ready;
  logic       dp_out, dm_out;
  logic       tx_busy, tx_done, tx_error;
  tx_state_t  state_dbg;
  logic [3:0] bit_cnt_dbg;
  logic [3:0] bit_timer_dbg;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  usb_tx_encoder #(.CLKS_PER_BIT(8), .STUFF_LIMIT(6)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_last      (tx_last),
    .tx_data_ready(tx_data_ready),
    .dp_out       (dp_out),
    .dm_out       (dm_out),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_error     (tx_error),
    .state_dbg    (state_dbg),
    .bit_cnt_dbg  (bit_cnt_dbg),
    .bit_timer_dbg(bit_timer_dbg)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line string per bit period: J, K, 0 (=SE0); -1 means "never happens"
  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    bit         drop;
    string      line;
    int         done_at;
    int         err_at;
    int         rdy0_at;
    int         rdy1_at;
  } vec_t;

  vec_t vecs[5];

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input byte c);
    if (c == "J") return 2'b10;
    if (c == "K") return 2'b01;
    return 2'b00;
  endfunction

  // drive one packet from the current point (just after a negedge) and
  // score the whole line trace until tx_busy falls
  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] trace [512];
    int start, idx, nrdy, ndone, nerr, next_byte;
    int rdy_at [2];
    int done_at, err_at, nper;
    bit upd, seen_end, ok;
    start = cyc;
    nrdy = 0; ndone = 0; nerr = 0; next_byte = 1;
    rdy_at[0] = -1; rdy_at[1] = -1; done_at = -1; err_at = -1;
    upd = 0; seen_end = 0; idx = 0;
    for (int i = 0; i < 512; i++) trace[i] = 2'b11;
    tx_data = v.b0;
    tx_last = (v.nbytes == 1) && !v.drop;
    tx_data_valid = 1'b1;
    for (int k = 0; k < 400 && !seen_end; k++) begin
      @(posedge clk); #1;
      if (upd) begin
        upd = 0;
        if (next_byte < v.nbytes) begin
          tx_data = v.b1;
          tx_last = (next_byte == v.nbytes - 1) && !v.drop;
        end else begin
          tx_data_valid = 1'b0;
          tx_last = 1'b0;
        end
        next_byte++;
      end
      @(negedge clk);
      idx = cyc - start - 1;
      if (idx >= 0 && idx < 512) trace[idx] = {dp_out, dm_out};
      if (tx_data_ready) begin
        if (nrdy < 2) rdy_at[nrdy] = cyc - start;
        nrdy++;
        upd = 1;
      end
      if (tx_done) begin ndone++; done_at = cyc - start; end
      if (tx_error) begin nerr++; err_at = cyc - start; end
      if (!tx_busy) seen_end = 1;
    end
    if (!seen_end) begin
      bad++; total++;
      $display("FAIL %s timeout: busy still %0d after 400 cycles want 0", tag, tx_busy);
    end
    nper = v.line.len();
    check_int({tag, " end_idx"}, idx, 8 * nper);
    for (int p = 0; p < nper; p++) begin
      ok = 1;
      for (int c = 0; c < 8; c++)
        if (trace[8*p + c] !== code_of(v.line[p])) ok = 0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s period %0d: got %b..%b want %b", tag, p, trace[8*p], trace[8*p+7],
                 code_of(v.line[p]));
      end
    end
    if (idx >= 0 && idx < 512) check_int({tag, " idle_line"}, int'(trace[idx]), int'(LINE_J));
    check_int({tag, " ready_cnt"}, nrdy, (v.rdy1_at >= 0) ? 2 : 1);
    check_int({tag, " ready0_at"}, rdy_at[0], v.rdy0_at);
    check_int({tag, " ready1_at"}, rdy_at[1], v.rdy1_at);
    check_int({tag, " done_cnt"}, ndone, (v.done_at >= 0) ? 1 : 0);
    check_int({tag, " done_at"}, done_at, v.done_at);
    check_int({tag, " err_cnt"}, nerr, (v.err_at >= 0) ? 1 : 0);
    check_int({tag, " err_at"}, err_at, v.err_at);
  endtask

  initial begin
    int start, nrdy, npulse;
    bit upd;

    vecs[0] = '{8'hA5, 8'h00, 1, 1'b0, "KJKJKJKKKJJKJJKK00J",         152, -1, 64, -1};
    vecs[1] = '{8'hFF, 8'h00, 1, 1'b0, "KJKJKJKKKKKKKJJJJ00J",        160, -1, 64, -1};
    vecs[2] = '{8'h3C, 8'hC3, 2, 1'b0, "KJKJKJKKJKKKKKJKKKJKJKKK00J", 216, -1, 64, 128};
    vecs[3] = '{8'h3C, 8'h00, 1, 1'b1, "KJKJKJKKJKKKKKJK00J",         -1, 128, 64, -1};
    vecs[4] = '{8'hFC, 8'h00, 1, 1'b0, "KJKJKJKKJKKKKKKKJ00J",        160, -1, 64, -1};

    // reset
    n_rst = 1'b1; tx_data = 8'h00; tx_data_valid = 1'b0; tx_last = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rst dp", dp_out, 1);
    check_int("rst dm", dm_out, 0);
    check_int("rst busy", tx_busy, 0);
    check_int("rst pulses", {tx_data_ready, tx_done, tx_error}, 0);
    check_int("rst state", int'(state_dbg), int'(ST_IDLE));
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_int("idle line", {dp_out, dm_out}, int'(LINE_J));

    // table
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end

    // back-to-back: second request in the first idle cycle after tx_done
    run_vec(vecs[0], "b2b_first");
    run_vec(vecs[2], "b2b_second");
    repeat (3) @(negedge clk);

    // reset during data bit 3 of 8'hA5 (period 11 spans cycles 89..96)
    start = cyc; nrdy = 0; npulse = 0; upd = 0;
    tx_data = 8'hA5; tx_last = 1'b1; tx_data_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (upd) begin tx_data_valid = 1'b0; tx_last = 1'b0; upd = 0; end
      @(negedge clk);
      if (tx_data_ready) begin nrdy++; upd = 1; end
      if (tx_done || tx_error) npulse++;
      if (cyc - start == 92) break;
    end
    check_int("mid state_before", int'(state_dbg), int'(ST_DATA));
    n_rst = 1'b1;
    tx_data_valid = 1'b0;
    @(negedge clk);
    check_int("mid rst line", {dp_out, dm_out}, int'(LINE_J));
    check_int("mid rst busy", tx_busy, 0);
    n_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_data_ready) nrdy++;
      if (tx_done || tx_error || tx_busy) npulse++;
    end
    check_int("mid ready_cnt", nrdy, 1);
    check_int("mid no_pulses", npulse, 0);
    run_vec(vecs[0], "after_rst");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
